mgt_01_freg_file_ctx: RTL and testbench
=======================================

# mgt_01_freg_file_ctx

Parametrised floating-point register file for MicroGT-01 with configurable width, depth and read-port count, optional write-to-read bypass, and a sequential context save/restore engine. The engine streams the whole file out or in one word per cycle over valid/ready handshakes, replacing single-cycle whole-file load/store so the block maps to block RAM/LUT RAM on FPGA. It sits beside the FPU issue stage; the context port connects to the trap/context-switch unit.

## Interface
- DATA_WIDTH, 32, register width in bits
- DEPTH, 32, number of registers (≥2, need not be a power of two)
- NUM_RD, 3, number of combinational read ports (≥1)
- BYPASS, 1, 1 = read of the address being written returns wr_data_i in the same cycle
- AW (localparam) = $clog2(DEPTH)

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  global clock enable; low freezes all state
- rd_addr_i  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
- rd_data_o  out  NUM_RD*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
- we_i  in  1  architectural write enable
- wr_addr_i  in  AW  write address
- wr_data_i  in  DATA_WIDTH  write data
- save_req_i  in  1  start context save (sampled in IDLE)
- restore_req_i  in  1  start context restore (sampled in IDLE)
- busy_o  out  1  engine active (state ≠ IDLE)
- done_o  out  1  one-cycle pulse after last save/restore beat
- sv_valid_o  out  1  save word valid
- sv_ready_i  in  1  save sink ready
- sv_data_o  out  DATA_WIDTH  save word, register sv_idx_o
- sv_idx_o  out  AW  index of current save/restore word
- rs_valid_i  in  1  restore word valid
- rs_ready_o  out  1  restore sink ready
- rs_data_i  in  DATA_WIDTH  restore word

## Operation
- FSM states: IDLE, SAVE, RESTORE. Index counter idx (AW bits) drives sv_idx_o in both modes.
- IDLE: we_i writes reg[wr_addr_i]. save_req_i → SAVE, idx=0. restore_req_i → RESTORE, idx=0. Both high: SAVE wins, restore ignored (not queued).
- SAVE: sv_valid_o=1, sv_data_o=reg[idx]. Beat on sv_valid_o&sv_ready_i: idx++. Beat at idx=DEPTH-1 → IDLE, idx=0, done_o next cycle.
- RESTORE: rs_ready_o=1. Beat on rs_valid_i&rs_ready_o: reg[idx]<=rs_data_i, idx++. Last beat (idx=DEPTH-1) → IDLE, done_o next cycle.
- While busy_o: we_i, save_req_i, restore_req_i ignored (issue stage stalls on busy_o). Reads stay live: SAVE sees a frozen snapshot; RESTORE sees partially restored contents.
- Read ports: rd_data_o[k]=reg[rd_addr_i[k]]. BYPASS=1 and IDLE&we_i&clk_en_i&addr match → wr_data_i. Address ≥ DEPTH: read returns 0, write ignored.
- clk_en_i=0: no state change; sv_valid_o and rs_ready_o forced 0 so no beat completes; done_o held 0 if the pulse cycle is frozen, then delivered on the next enabled cycle.
- Width: idx increments modulo nothing—terminal compare at DEPTH-1, never wraps past it.

## Timing
- Async reset: all registers 0, state IDLE, idx 0; busy_o=0, done_o=0, sv_valid_o=0, rs_ready_o=0, sv_idx_o=0, sv_data_o=0 (=reg[0]), rd_data_o=0.
- Reset mid-SAVE/RESTORE: abort immediately, IDLE, no done_o; partially restored registers cleared by reset.
- Writes: one-cycle latency (visible on reads next cycle; same cycle only via bypass).
- Request sampled at edge N; busy_o and first sv_valid_o/rs_ready_o from cycle N+1.
- Full-throughput save/restore: DEPTH beats in cycles N+1..N+DEPTH; done_o=1 in cycle N+DEPTH+1 with busy_o=0; a new request in that cycle is accepted.
- save_req_i with we_i at same edge in IDLE: write commits, snapshot includes it.

## Test plan
- Reset then write reg[5]=0x3F800000, read port 2 addr 5 next cycle -> 0x3F800000; same-cycle read with BYPASS=1 -> 0x3F800000, BYPASS=0 -> 0.
- Fill reg[i]=i+0x100, save with sv_ready_i=1 -> 32 beats, sv_data_o=0x100..0x11F, sv_idx_o 0..31, done_o in cycle 34 after request.
- Save with sv_ready_i toggling 1010…, we_i=1 to reg[0] during SAVE -> sequence unchanged, reg[0] unmodified, 64 cycles.
- Restore 0xA000+i with rs_valid_i gaps and clk_en_i low for 3 cycles mid-stream -> reg[i]=0xA000+i, no beats while disabled, single done_o.
- save_req_i & restore_req_i together -> SAVE only; rst_n_i low at beat 10 of RESTORE -> IDLE, all regs 0, no done_o.
- DEPTH=24, NUM_RD=1: read addr 30 -> 0, write addr 30 ignored, save emits exactly 24 beats.

Source files
------------

// File: rtl/mgt_01_freg_file_ctx_if.sv
// mgt_01_freg_file_ctx_if: read/write ports and save/restore streams of the FP register file.
interface mgt_01_freg_file_ctx_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_RD     = 3
);
   localparam int AW = $clog2(DEPTH);
   logic [NUM_RD*AW-1:0]         rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic                         we;
   logic [AW-1:0]                wr_addr;
   logic [DATA_WIDTH-1:0]        wr_data;
   logic                         save_req;
   logic                         restore_req;
   logic                         busy;
   logic                         done;
   logic                         sv_valid;
   logic                         sv_ready;
   logic [DATA_WIDTH-1:0]        sv_data;
   logic [AW-1:0]                sv_idx;
   logic                         rs_valid;
   logic                         rs_ready;
   logic [DATA_WIDTH-1:0]        rs_data;
   modport master (
      output rd_addr, we, wr_addr, wr_data, save_req, restore_req, sv_ready, rs_valid, rs_data,
      input  rd_data, busy, done, sv_valid, sv_data, sv_idx, rs_ready
   );
   modport slave (
      input  rd_addr, we, wr_addr, wr_data, save_req, restore_req, sv_ready, rs_valid, rs_data,
      output rd_data, busy, done, sv_valid, sv_data, sv_idx, rs_ready
   );
endinterface

// File: rtl/mgt_01_freg_file_ctx.sv
// mgt_01_freg_file_ctx: FP register file with read bypass and a streaming context save/restore engine.
// One write port shared by architectural writes (IDLE) and restore beats (RESTORE).
module mgt_01_freg_file_ctx #(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 32,
   parameter int  NUM_RD     = 3,
   parameter bit  BYPASS     = 1'b1,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clk_en_i,
   mgt_01_freg_file_ctx_if.slave bus
);
   localparam logic [1:0]    S_IDLE    = 2'd0;
   localparam logic [1:0]    S_SAVE    = 2'd1;
   localparam logic [1:0]    S_RESTORE = 2'd2;
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST      = AW'(DEPTH-1);
   logic [1:0]            state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic                  arch_we, beat, wen;
   logic [AW-1:0]         widx;
   logic [DATA_WIDTH-1:0] wdat;
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_C;
   endfunction
   assign arch_we      = (state_q == S_IDLE) && bus.we && in_range(bus.wr_addr);
   assign bus.sv_valid = (state_q == S_SAVE) && clk_en_i;
   assign bus.rs_ready = (state_q == S_RESTORE) && clk_en_i;
   assign beat         = (bus.sv_valid && bus.sv_ready) || (bus.rs_ready && bus.rs_valid);
   assign bus.busy     = state_q != S_IDLE;
   assign bus.done     = done_q && clk_en_i;
   assign bus.sv_idx   = idx_q;
   assign bus.sv_data  = regs_q[idx_q];
   assign wen          = arch_we || (bus.rs_ready && bus.rs_valid);
   assign widx         = (state_q == S_IDLE) ? bus.wr_addr : idx_q;
   assign wdat         = (state_q == S_IDLE) ? bus.wr_data : bus.rs_data;
   // save wins over restore when both are raised; idx stays 0 while idle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (state_q == S_IDLE)
         state_d = bus.save_req ? S_SAVE : bus.restore_req ? S_RESTORE : S_IDLE;
      else if (beat) begin
         idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
         state_d = (idx_q == LAST) ? S_IDLE : state_q;
         done_d  = idx_q == LAST;
      end
   end
   always_comb begin
      bus.rd_data = '0;
      for (int k = 0; k < NUM_RD; k++)
         bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
            (BYPASS && arch_we && clk_en_i && bus.rd_addr[k*AW +: AW] == bus.wr_addr) ? bus.wr_data :
            in_range(bus.rd_addr[k*AW +: AW]) ? regs_q[bus.rd_addr[k*AW +: AW]] : '0;
   end
   // a frozen cycle holds done_q, so the pulse lands on the next enabled cycle
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (clk_en_i) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         if (wen) regs_q[widx] <= wdat;
      end
   end
endmodule

// File: tb/tb_mgt_01_freg_file_ctx.sv
// tb_mgt_01_freg_file_ctx: directed tests of the FP register file and its context engine.
module tb_mgt_01_freg_file_ctx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   mgt_01_freg_file_ctx_if #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(3)) b0 ();
   mgt_01_freg_file_ctx_if #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(3)) b1 ();
   mgt_01_freg_file_ctx_if #(.DATA_WIDTH(32), .DEPTH(24), .NUM_RD(1)) b2 ();
   mgt_01_freg_file_ctx #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(3), .BYPASS(1'b1)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .bus(b0));
   mgt_01_freg_file_ctx #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(3), .BYPASS(1'b0)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .bus(b1));
   mgt_01_freg_file_ctx #(.DATA_WIDTH(32), .DEPTH(24), .NUM_RD(1), .BYPASS(1'b1)) u2 (
      .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .bus(b2));
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_all();
      b0.rd_addr = '0; b0.we = 0; b0.wr_addr = '0; b0.wr_data = '0; b0.save_req = 0;
      b0.restore_req = 0; b0.sv_ready = 0; b0.rs_valid = 0; b0.rs_data = '0;
      b1.rd_addr = '0; b1.we = 0; b1.wr_addr = '0; b1.wr_data = '0; b1.save_req = 0;
      b1.restore_req = 0; b1.sv_ready = 0; b1.rs_valid = 0; b1.rs_data = '0;
      b2.rd_addr = '0; b2.we = 0; b2.wr_addr = '0; b2.wr_data = '0; b2.save_req = 0;
      b2.restore_req = 0; b2.sv_ready = 0; b2.rs_valid = 0; b2.rs_data = '0;
   endtask
   task automatic test_reset();
      idle_all();
      #12;
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", b0.busy); end
      checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", b0.done); end
      checks++; if (b0.sv_valid !== 1'b0) begin failures++; $display("FAIL rst_sv_valid got=%0h exp=0", b0.sv_valid); end
      checks++; if (b0.rs_ready !== 1'b0) begin failures++; $display("FAIL rst_rs_ready got=%0h exp=0", b0.rs_ready); end
      checks++; if (b0.sv_idx !== 5'd0) begin failures++; $display("FAIL rst_sv_idx got=%0h exp=0", b0.sv_idx); end
      checks++; if (b0.sv_data !== 32'd0) begin failures++; $display("FAIL rst_sv_data got=%0h exp=0", b0.sv_data); end
      checks++; if (b0.rd_data !== 96'd0) begin failures++; $display("FAIL rst_rd_data got=%0h exp=0", b0.rd_data); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   task automatic test_write_bypass();
      cyc();
      b0.we = 1; b0.wr_addr = 5'd5; b0.wr_data = 32'h3F80_0000; b0.rd_addr = {5'd5, 5'd0, 5'd0};
      b1.we = 1; b1.wr_addr = 5'd5; b1.wr_data = 32'h3F80_0000; b1.rd_addr = {5'd5, 5'd0, 5'd0};
      #1;
      checks++; if (b0.rd_data[95:64] !== 32'h3F80_0000) begin failures++; $display("FAIL byp1_same got=%0h exp=3f800000", b0.rd_data[95:64]); end
      checks++; if (b1.rd_data[95:64] !== 32'h0) begin failures++; $display("FAIL byp0_same got=%0h exp=0", b1.rd_data[95:64]); end
      checks++; if (b0.rd_data[31:0] !== 32'h0) begin failures++; $display("FAIL byp1_other_port got=%0h exp=0", b0.rd_data[31:0]); end
      cyc();
      b0.we = 0; b1.we = 0;
      #1;
      checks++; if (b0.rd_data[95:64] !== 32'h3F80_0000) begin failures++; $display("FAIL byp1_next got=%0h exp=3f800000", b0.rd_data[95:64]); end
      checks++; if (b1.rd_data[95:64] !== 32'h3F80_0000) begin failures++; $display("FAIL byp0_next got=%0h exp=3f800000", b1.rd_data[95:64]); end
   endtask
   task automatic test_save_full();
      for (int i = 0; i < 32; i++) begin
         cyc();
         b0.we = 1; b0.wr_addr = 5'(i); b0.wr_data = 32'h100 + i;
      end
      cyc();
      b0.we = 0; b0.save_req = 1; b0.sv_ready = 1;
      cyc();
      b0.save_req = 0;
      #1;
      for (int j = 0; j < 32; j++) begin
         checks++; if (b0.sv_valid !== 1'b1) begin failures++; $display("FAIL save_valid beat=%0d got=%0h exp=1", j, b0.sv_valid); end
         checks++; if (b0.sv_idx !== 5'(j)) begin failures++; $display("FAIL save_idx beat=%0d got=%0h exp=%0h", j, b0.sv_idx, j); end
         checks++; if (b0.sv_data !== 32'h100 + j) begin failures++; $display("FAIL save_data beat=%0d got=%0h exp=%0h", j, b0.sv_data, 32'h100 + j); end
         checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL save_early_done beat=%0d got=%0h exp=0", j, b0.done); end
         cyc();
         #1;
      end
      checks++; if (b0.done !== 1'b1) begin failures++; $display("FAIL save_done got=%0h exp=1", b0.done); end
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL save_busy_at_done got=%0h exp=0", b0.busy); end
      cyc();
      #1;
      checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL save_done_pulse got=%0h exp=0", b0.done); end
      b0.sv_ready = 0;
   endtask
   task automatic test_save_throttled();
      b0.save_req = 1;
      cyc();
      b0.save_req = 0;
      for (int c = 1; c <= 64; c++) begin
         b0.sv_ready = (c % 2 == 1);
         b0.we = (c < 64); b0.wr_addr = 5'd0; b0.wr_data = 32'hDEAD_BEEF;
         #1;
         if (c < 64) begin
            checks++; if (b0.sv_idx !== 5'(c / 2)) begin failures++; $display("FAIL thr_idx cyc=%0d got=%0h exp=%0h", c, b0.sv_idx, c / 2); end
            checks++; if (b0.sv_data !== 32'h100 + c / 2) begin failures++; $display("FAIL thr_data cyc=%0d got=%0h exp=%0h", c, b0.sv_data, 32'h100 + c / 2); end
         end else begin
            checks++; if (b0.done !== 1'b1) begin failures++; $display("FAIL thr_done got=%0h exp=1", b0.done); end
         end
         cyc();
      end
      b0.sv_ready = 0; b0.rd_addr = '0;
      #1;
      checks++; if (b0.rd_data[31:0] !== 32'h100) begin failures++; $display("FAIL thr_reg0 got=%0h exp=100", b0.rd_data[31:0]); end
   endtask
   task automatic test_restore();
      int ei;
      int cnt;
      ei = 0;
      cnt = 0;
      cyc();
      b0.restore_req = 1;
      cyc();
      b0.restore_req = 0;
      while (ei < 32 && cnt < 200) begin
         clk_en = !(cnt >= 10 && cnt <= 12);
         b0.rs_valid = (cnt % 3 != 2);
         b0.rs_data = 32'hA000 + ei;
         #1;
         checks++; if (b0.rs_ready !== clk_en) begin failures++; $display("FAIL rs_ready cyc=%0d got=%0h exp=%0h", cnt, b0.rs_ready, clk_en); end
         checks++; if (b0.sv_idx !== 5'(ei)) begin failures++; $display("FAIL rs_idx cyc=%0d got=%0h exp=%0h", cnt, b0.sv_idx, ei); end
         if (clk_en && b0.rs_valid) ei++;
         cyc();
         cnt++;
      end
      checks++; if (ei != 32) begin failures++; $display("FAIL rs_timeout beats=%0d exp=32", ei); end
      clk_en = 0; b0.rs_valid = 0;
      #1;
      checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL rs_done_frozen got=%0h exp=0", b0.done); end
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL rs_busy_end got=%0h exp=0", b0.busy); end
      cyc();
      clk_en = 1;
      #1;
      checks++; if (b0.done !== 1'b1) begin failures++; $display("FAIL rs_done_late got=%0h exp=1", b0.done); end
      cyc();
      #1;
      checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL rs_done_single got=%0h exp=0", b0.done); end
      for (int i = 0; i < 32; i++) begin
         b0.rd_addr = {3{5'(i)}};
         #1;
         checks++; if (b0.rd_data[31:0] !== 32'hA000 + i) begin failures++; $display("FAIL rs_reg%0d got=%0h exp=%0h", i, b0.rd_data[31:0], 32'hA000 + i); end
      end
   endtask
   task automatic test_both_and_abort();
      logic saw_done;
      cyc();
      b0.save_req = 1; b0.restore_req = 1; b0.sv_ready = 1;
      cyc();
      b0.save_req = 0; b0.restore_req = 0;
      #1;
      checks++; if (b0.sv_valid !== 1'b1) begin failures++; $display("FAIL both_sv_valid got=%0h exp=1", b0.sv_valid); end
      checks++; if (b0.rs_ready !== 1'b0) begin failures++; $display("FAIL both_rs_ready got=%0h exp=0", b0.rs_ready); end
      checks++; if (b0.sv_data !== 32'hA000) begin failures++; $display("FAIL both_sv_data got=%0h exp=a000", b0.sv_data); end
      for (int j = 0; j < 32; j++) cyc();
      #1;
      checks++; if (b0.done !== 1'b1) begin failures++; $display("FAIL both_done got=%0h exp=1", b0.done); end
      cyc();
      b0.sv_ready = 0;
      #1;
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL both_no_restore got=%0h exp=0", b0.busy); end
      b0.restore_req = 1; b0.rs_valid = 1;
      cyc();
      b0.restore_req = 0;
      for (int j = 0; j < 10; j++) begin
         b0.rs_data = 32'hB000 + j;
         cyc();
      end
      b0.rs_data = 32'hB00A;
      #1;
      checks++; if (b0.sv_idx !== 5'd10) begin failures++; $display("FAIL abort_idx got=%0h exp=a", b0.sv_idx); end
      rst_n = 0;
      #1;
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0h exp=0", b0.busy); end
      checks++; if (b0.rs_ready !== 1'b0) begin failures++; $display("FAIL abort_rs_ready got=%0h exp=0", b0.rs_ready); end
      checks++; if (b0.sv_idx !== 5'd0) begin failures++; $display("FAIL abort_sv_idx got=%0h exp=0", b0.sv_idx); end
      b0.rs_valid = 0; b0.rd_addr = {5'd9, 5'd5, 5'd0};
      #1;
      checks++; if (b0.rd_data !== 96'd0) begin failures++; $display("FAIL abort_regs got=%0h exp=0", b0.rd_data); end
      cyc();
      rst_n = 1;
      saw_done = 0;
      for (int j = 0; j < 4; j++) begin
         #1;
         if (b0.done) saw_done = 1;
         cyc();
      end
      checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0h exp=0", saw_done); end
   endtask
   task automatic test_small_depth();
      int beats;
      logic saw_done;
      logic [31:0] first_w, last_w;
      beats = 0; saw_done = 0; first_w = '0; last_w = '0;
      b2.we = 1; b2.wr_addr = 5'd30; b2.wr_data = 32'h55; b2.rd_addr = 5'd30;
      #1;
      checks++; if (b2.rd_data !== 32'h0) begin failures++; $display("FAIL d24_oob_bypass got=%0h exp=0", b2.rd_data); end
      cyc();
      b2.wr_addr = 5'd23; b2.wr_data = 32'h77;
      #1;
      checks++; if (b2.rd_data !== 32'h0) begin failures++; $display("FAIL d24_oob_read got=%0h exp=0", b2.rd_data); end
      cyc();
      b2.wr_addr = 5'd0; b2.wr_data = 32'h11; b2.rd_addr = 5'd23;
      #1;
      checks++; if (b2.rd_data !== 32'h77) begin failures++; $display("FAIL d24_reg23 got=%0h exp=77", b2.rd_data); end
      cyc();
      b2.we = 0; b2.save_req = 1; b2.sv_ready = 1;
      cyc();
      b2.save_req = 0;
      for (int n = 0; n < 60 && !saw_done; n++) begin
         #1;
         if (b2.sv_valid && b2.sv_ready) begin
            beats++;
            last_w = b2.sv_data;
            if (b2.sv_idx == 5'd0) first_w = b2.sv_data;
         end
         if (b2.done) saw_done = 1;
         cyc();
      end
      checks++; if (saw_done !== 1'b1) begin failures++; $display("FAIL d24_done got=%0h exp=1", saw_done); end
      checks++; if (beats != 24) begin failures++; $display("FAIL d24_beats got=%0d exp=24", beats); end
      checks++; if (first_w !== 32'h11) begin failures++; $display("FAIL d24_first got=%0h exp=11", first_w); end
      checks++; if (last_w !== 32'h77) begin failures++; $display("FAIL d24_last got=%0h exp=77", last_w); end
      b2.sv_ready = 0;
   endtask
   initial begin
      test_reset();
      test_write_bypass();
      test_save_full();
      test_save_throttled();
      test_restore();
      test_both_and_abort();
      test_small_depth();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
